// File: rtl/hub75_column_loader.sv
// Loads one HUB75 scan-line pair (rows r and r+SCAN_RATE) of a theta slice from a
// pipelined frame buffer and offers it downstream with a valid/ready handshake.
module hub75_column_loader #(
  parameter int NUM_COLS     = 64,
  parameter int NUM_ROWS     = 64,
  parameter int SCAN_RATE    = 32,
  parameter int THETA_RES    = 8,
  parameter int RGB_RES      = 9,
  parameter int BRAM_LATENCY = 2
) (
  input  logic                                                     clk_in,
  input  logic                                                     rst_in,
  input  logic [THETA_RES-1:0]                                     theta_in,
  input  logic                                                     theta_valid,
  output logic [THETA_RES+$clog2(NUM_ROWS)+$clog2(NUM_COLS)-1:0]   bram_addr,
  output logic                                                     bram_en,
  input  logic [RGB_RES-1:0]                                       bram_data,
  output logic [1:0][NUM_COLS-1:0][RGB_RES-1:0]                    column_data,
  output logic [$clog2(SCAN_RATE)-1:0]                             address_data,
  output logic                                                     tvalid,
  input  logic                                                     tready
);

  localparam int COL_W  = $clog2(NUM_COLS);
  localparam int ROW_W  = $clog2(NUM_ROWS);
  localparam int SCAN_W = $clog2(SCAN_RATE);
  localparam int K_W    = COL_W + 1;
  localparam int D_W    = $clog2(BRAM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, PRESENT} state_t;

  state_t                                  state_q, state_d;
  logic                                    pend_vld_q, pend_vld_d;
  logic [THETA_RES-1:0]                    pend_theta_q, pend_theta_d;
  logic [THETA_RES-1:0]                    cur_theta_q, cur_theta_d;
  logic [SCAN_W-1:0]                       r_q, r_d;
  logic [K_W-1:0]                          k_q, k_d;
  logic [D_W-1:0]                          drain_q, drain_d;
  logic [BRAM_LATENCY-1:0]                 pipe_vld_q, pipe_vld_d;
  logic [BRAM_LATENCY-1:0][K_W-1:0]        pipe_idx_q, pipe_idx_d;
  logic [1:0][NUM_COLS-1:0][RGB_RES-1:0]   col_q, col_d;

  logic              fetch_last;
  logic              drain_last;
  logic              handshake;
  logic              frame_end;
  logic [ROW_W-1:0]  fetch_row;
  logic [K_W-1:0]    ret_idx;

  // k's top bit selects the lower half-panel row (r + SCAN_RATE); NUM_COLS is a power of two.
  assign fetch_last = (k_q == K_W'(2 * NUM_COLS - 1));
  assign drain_last = (drain_q == D_W'(BRAM_LATENCY - 1));
  assign handshake  = (state_q == PRESENT) && tready;
  assign frame_end  = (r_q == SCAN_W'(SCAN_RATE - 1));
  assign fetch_row  = ROW_W'(r_q) + (k_q[K_W-1] ? ROW_W'(SCAN_RATE) : ROW_W'(0));
  assign ret_idx    = pipe_idx_q[BRAM_LATENCY-1];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      pend_vld_q   <= 1'b0;
      pend_theta_q <= '0;
      cur_theta_q  <= '0;
      r_q          <= '0;
      k_q          <= '0;
      drain_q      <= '0;
      pipe_vld_q   <= '0;
      pipe_idx_q   <= '0;
      col_q        <= '0;
    end else begin
      state_q      <= state_d;
      pend_vld_q   <= pend_vld_d;
      pend_theta_q <= pend_theta_d;
      cur_theta_q  <= cur_theta_d;
      r_q          <= r_d;
      k_q          <= k_d;
      drain_q      <= drain_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_idx_q   <= pipe_idx_d;
      col_q        <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pend_vld_q) state_d = FETCH;
      FETCH:   if (fetch_last) state_d = DRAIN;
      DRAIN:   if (drain_last) state_d = PRESENT;
      PRESENT: if (tready)     state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // A strobe coincident with the frame-wrap handshake is taken directly, so it lands in the next frame.
  always_comb begin
    pend_vld_d   = pend_vld_q;
    pend_theta_d = pend_theta_q;
    cur_theta_d  = cur_theta_q;
    r_d          = r_q;
    k_d          = k_q;
    drain_d      = drain_q;
    if (theta_valid) begin
      pend_vld_d   = 1'b1;
      pend_theta_d = theta_in;
    end
    case (state_q)
      IDLE: begin
        if (pend_vld_q) begin
          cur_theta_d = pend_theta_q;
          pend_vld_d  = theta_valid;
          r_d         = '0;
          k_d         = '0;
        end
      end
      FETCH: begin
        k_d     = fetch_last ? '0 : k_q + K_W'(1);
        drain_d = '0;
      end
      DRAIN: begin
        drain_d = drain_last ? '0 : drain_q + D_W'(1);
      end
      PRESENT: begin
        if (handshake) begin
          k_d = '0;
          if (frame_end) begin
            r_d = '0;
            if (theta_valid) begin
              cur_theta_d = theta_in;
              pend_vld_d  = 1'b0;
            end else if (pend_vld_q) begin
              cur_theta_d = pend_theta_q;
              pend_vld_d  = 1'b0;
            end
          end else begin
            r_d = r_q + SCAN_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Issue indices ride alongside the BRAM read so each returning word knows its slot.
  always_comb begin
    pipe_vld_d    = '0;
    pipe_idx_d    = '0;
    pipe_vld_d[0] = (state_q == FETCH);
    pipe_idx_d[0] = k_q;
    for (int i = 1; i < BRAM_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_idx_d[i] = pipe_idx_q[i-1];
    end
    col_d = col_q;
    if (pipe_vld_q[BRAM_LATENCY-1]) begin
      col_d[ret_idx[K_W-1]][ret_idx[COL_W-1:0]] = bram_data;
    end
  end

  always_comb begin
    tvalid       = (state_q == PRESENT);
    bram_en      = (state_q == FETCH);
    address_data = r_q;
    column_data  = col_q;
    bram_addr    = '0;
    if (state_q == FETCH) begin
      bram_addr = {cur_theta_q, fetch_row, k_q[COL_W-1:0]};
    end
  end

endmodule

// File: doc/hub75_column_loader.md
HUB75_COLUMN_LOADER -- requirements
Module: hub75_column_loader

Interface
REQ-001 SHALL have parameter NUM_COLS, default 64, meaning pixels per panel row (columns shifted per latch).
REQ-002 SHALL have parameter NUM_ROWS, default 64, meaning panel rows per theta slice.
REQ-003 SHALL have parameter SCAN_RATE, default 32, meaning scan addresses per frame (row pairs r and r+SCAN_RATE).
REQ-004 SHALL have parameter THETA_RES, default 8, meaning bits of rotational slice index.
REQ-005 SHALL have parameter RGB_RES, default 9, meaning bits per pixel word.
REQ-006 SHALL have parameter BRAM_LATENCY, default 2, meaning frame-buffer read latency in cycles (>=1).
REQ-007 SHALL: clk_in input 1 -- single clock; all logic on its rising edge.
REQ-008 SHALL: rst_in input 1 -- reset, asynchronous, active-high.
REQ-009 SHALL: theta_in input THETA_RES -- slice index to display.
REQ-010 SHALL: theta_valid input 1 -- one-cycle strobe qualifying theta_in.
REQ-011 SHALL: bram_addr output THETA_RES+clog2(NUM_ROWS)+clog2(NUM_COLS) -- {theta, row, col}.
REQ-012 SHALL: bram_en output 1 -- read enable, high only on cycles issuing a valid address.
REQ-013 SHALL: bram_data input RGB_RES -- read data, valid BRAM_LATENCY cycles after its address.
REQ-014 SHALL: column_data output [1:0][NUM_COLS-1:0][RGB_RES-1:0] -- [0]=row r, [1]=row r+SCAN_RATE.
REQ-015 SHALL: address_data output clog2(SCAN_RATE) -- scan address r of column_data.
REQ-016 SHALL: tvalid output 1 / tready input 1 -- AXI-Stream-style handshake to downstream HUB75 driver.

Function
REQ-017 SHALL implement states IDLE, FETCH, DRAIN, PRESENT.
REQ-018 IDLE: no pending slice -> stay; pending slice -> latch it as cur_theta, clear pending, r=0, go FETCH.
REQ-019 theta_valid SHALL store theta_in as pending in any state; multiple strobes before use: last wins.
REQ-020 FETCH SHALL issue exactly 2*NUM_COLS reads, one per cycle, index k=0..2*NUM_COLS-1: half=k/NUM_COLS, col=k mod NUM_COLS, row=r+half*SCAN_RATE.
REQ-021 Each returned word SHALL be written to column_data[half][col] of its issuing index via a BRAM_LATENCY-deep index pipeline.
REQ-022 After last issue -> DRAIN for exactly BRAM_LATENCY cycles (bram_en=0), then PRESENT.
REQ-023 tvalid SHALL assert on first PRESENT cycle = 2*NUM_COLS+BRAM_LATENCY cycles after first bram_en cycle.
REQ-024 In PRESENT column_data, address_data, tvalid SHALL hold stable until tready sampled high with tvalid.
REQ-025 On handshake: tvalid deasserts next cycle; r<SCAN_RATE-1 -> r+1, FETCH same cur_theta.
REQ-026 On handshake with r=SCAN_RATE-1 (frame wrap): r=0; pending present -> latch it, clear pending; else reuse cur_theta; go FETCH.
REQ-027 theta_valid coincident with wrap handshake SHALL be used for the next frame.
REQ-028 tvalid SHALL never assert outside PRESENT; tready outside PRESENT ignored.
REQ-029 Counters SHALL wrap without overflow; r width clog2(SCAN_RATE).

Reset
REQ-030 rst_in high SHALL immediately force IDLE, tvalid=0, bram_en=0, bram_addr=0, address_data=0, column_data=0, r=0, pending cleared, cur_theta=0.
REQ-031 Reset mid-FETCH/DRAIN/PRESENT SHALL abort; in-flight read data discarded; no tvalid until a new theta_valid.

Verification
REQ-032 Reset then theta_valid theta=5, BRAM model word=addr low bits, tready=1 -> first bram_addr={5,0,0}, tvalid after 130 cycles, column_data[1][3]=word at {5,32,3}, address_data=0.
REQ-033 tready=0 for 20 cycles in PRESENT -> tvalid and column_data stable all 20 cycles; one handshake only.
REQ-034 Full frame tready=1 -> address_data 0..31 in order, then wraps to 0 re-reading theta=5 (no new strobe).
REQ-035 theta_valid 7 then 9 during r=10 -> r=11..31 still theta 5; next frame uses 9.
REQ-036 rst_in pulse at FETCH k=40 -> tvalid stays 0, bram_en 0 until new theta_valid; following load exact.
REQ-037 BRAM_LATENCY=1 and 3 builds -> tvalid rise at 129 / 131 cycles; data bit-exact.
